ps2_byte_receiver: RTL and testbench

- Upstream stage of the keyboard path. Deserialises the PS/2 device-to-host frame (start, 8 data LSB-first, odd parity, stop) from the PS2_CLK/PS2_DAT pad inputs.
- Delivers each good byte as received_data with a one-cycle received_data_en strobe. This is the interface the scancode decoder (Enter/Left/Right make/break logic) consumes.
- Receive-only. Host-to-device transmit and the open-drain inout drivers stay outside this block.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_signal_filter.sv | 52 +++++
 rtl/ps2_byte_receiver.sv | 129 ++++++++++++
 tb/tb_ps2_byte_receiver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and the scancode values the downstream decoder matches on.
package ps2_pkg;

  // Receiver frame position: start bit seen -> data bits -> parity bit -> stop bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int PS2_DATA_BITS = 8;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_signal_filter.sv
// Synchroniser plus stability filter for one asynchronous PS/2 pad input.
// The output only moves once the synchronised input has disagreed with it
// for FILTER_LEN consecutive cycles, so short glitches on the line vanish.
module ps2_signal_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic pad,
  output logic filtered
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FILTER_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          stable_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability chain; idles high like the bus so reset does not look like a fall.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= pad;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Count consecutive samples that disagree with the filtered level and flip once enough agree.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filtered   <= 1'b1;
      stable_cnt <= '0;
    end else if (synced != filtered) begin
      if (stable_cnt == FILTER_LAST) begin
        filtered   <= synced;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver: filters the pad lines, samples data on
// each falling PS/2 clock edge and emits one pulse per completed frame
// (good byte, parity error or framing error).
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);

  logic clk_filt;
  logic dat_filt;
  logic clk_filt_q;
  logic fall;

  rx_state_t                state;
  logic [BW-1:0]            bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic                     parity_bit;
  logic [TW-1:0]            timeout_cnt;

  // Clock and data share the same filter so their relative timing is preserved.
  ps2_signal_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .pad     (ps2_clk_in),
    .filtered(clk_filt)
  );

  ps2_signal_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filter (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .pad     (ps2_dat_in),
    .filtered(dat_filt)
  );

  assign fall = clk_filt_q & ~clk_filt;

  // Frame FSM with timeout watchdog; every output is registered and pulses for one cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_filt_q       <= 1'b1;
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      parity_bit       <= 1'b0;
      timeout_cnt      <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      clk_filt_q       <= clk_filt;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      frame_error      <= 1'b0;

      if (fall) begin
        timeout_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_filt) begin
              state     <= DATA;
              bit_cnt   <= '0;
              shift_reg <= '0;
            end
          end
          DATA: begin
            shift_reg[bit_cnt] <= dat_filt;
            if (bit_cnt == BIT_LAST) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            parity_bit <= dat_filt;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_filt) begin
              frame_error <= 1'b1;
            end else if (((^shift_reg) ^ parity_bit) != 1'b1) begin
              parity_error <= 1'b1;
            end else begin
              received_data    <= shift_reg;
              received_data_en <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timeout_cnt == TIMEOUT_LAST) begin
          frame_error <= 1'b1;
          state       <= IDLE;
          shift_reg   <= '0;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
      end else begin
        timeout_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed bench for ps2_byte_receiver. The watchdog and PS/2 bit period are
// shortened so the whole run stays short while keeping bit period well under
// the timeout.
module tb_ps2_byte_receiver;

  localparam int TB_TIMEOUT = 1000;
  localparam int HALF       = 200;
  localparam int QUARTER    = HALF / 2;
  localparam int SYNC       = 2;
  localparam int FILT       = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_error;
  logic       frame_error;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc        = 0;
  int en_count   = 0;
  int perr_count = 0;
  int ferr_count = 0;
  int wide_count = 0;
  int ferr_cyc   = 0;
  int cap_n      = 0;
  logic [7:0] cap [0:31];
  logic en_prev = 1'b0;
  logic perr_prev = 1'b0;
  logic ferr_prev = 1'b0;
  int last_fall_cyc = 0;

  ps2_byte_receiver #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .ps2_clk_in      (ps2_clk_in),
    .ps2_dat_in      (ps2_dat_in),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .parity_error    (parity_error),
    .frame_error     (frame_error)
  );

  // 50 MHz system clock.
  always #10 CLOCK_50 = ~CLOCK_50;

  // Free-running cycle count used to time the watchdog.
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Tally output pulses on the inactive edge, capture the byte at each strobe and note any pulse wider than one cycle.
  always @(negedge CLOCK_50) begin
    if (received_data_en) begin
      en_count <= en_count + 1;
      if (cap_n < 32) cap[cap_n] <= received_data;
      cap_n <= cap_n + 1;
    end
    if (parity_error) perr_count <= perr_count + 1;
    if (frame_error) begin
      ferr_count <= ferr_count + 1;
      ferr_cyc   <= cyc;
    end
    if ((received_data_en && en_prev) || (parity_error && perr_prev) || (frame_error && ferr_prev))
      wide_count <= wide_count + 1;
    en_prev   <= received_data_en;
    perr_prev <= parity_error;
    ferr_prev <= frame_error;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // One PS/2 bit: data set while clock is high, clock falls mid-bit.
  task automatic applyStimulus(input logic b);
    ps2_dat_in = b;
    wait_cycles(QUARTER);
    ps2_clk_in = 1'b0;
    last_fall_cyc = cyc;
    wait_cycles(HALF);
    ps2_clk_in = 1'b1;
    wait_cycles(QUARTER);
  endtask

  // Sends the first nbits of start, data LSB-first, parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int nbits);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) applyStimulus(bits[i]);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      n_cmp++;
      if ({received_data_en, parity_error, frame_error} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL reset_pulses cycle %0d: got %b expected 000", i, {received_data_en, parity_error, frame_error});
      end
    end
    n_cmp++;
    if (received_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h expected 00", received_data);
    end
    reset = 1'b0;
    wait_cycles(20);
  endtask

  task automatic test_single_frame;
    int e0, c0, p0, f0, w0;
    e0 = en_count; c0 = cap_n; p0 = perr_count; f0 = ferr_count; w0 = wide_count;
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    wait_cycles(40);
    n_cmp++;
    if (en_count - e0 !== 1) begin n_fail++; $display("[TB] FAIL single_en_count: got %0d expected 1", en_count - e0); end
    n_cmp++;
    if (cap[c0] !== 8'h5A) begin n_fail++; $display("[TB] FAIL single_data_at_en: got %h expected 5a", cap[c0]); end
    n_cmp++;
    if (received_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL single_data_hold: got %h expected 5a", received_data); end
    n_cmp++;
    if ((perr_count - p0) + (ferr_count - f0) !== 0) begin n_fail++; $display("[TB] FAIL single_errors: got %0d expected 0", (perr_count - p0) + (ferr_count - f0)); end
    n_cmp++;
    if (wide_count - w0 !== 0) begin n_fail++; $display("[TB] FAIL single_pulse_width: got %0d wide pulses expected 0", wide_count - w0); end
  endtask

  task automatic test_back_to_back;
    int e0, c0, p0, f0;
    logic [7:0] exp_b [0:2];
    exp_b[0] = 8'hE0; exp_b[1] = 8'hF0; exp_b[2] = 8'h74;
    e0 = en_count; c0 = cap_n; p0 = perr_count; f0 = ferr_count;
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h74, 1'b1, 1'b1, 11);
    wait_cycles(40);
    n_cmp++;
    if (en_count - e0 !== 3) begin n_fail++; $display("[TB] FAIL burst_en_count: got %0d expected 3", en_count - e0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cap[c0 + i] !== exp_b[i]) begin n_fail++; $display("[TB] FAIL burst_byte%0d: got %h expected %h", i, cap[c0 + i], exp_b[i]); end
    end
    n_cmp++;
    if ((perr_count - p0) + (ferr_count - f0) !== 0) begin n_fail++; $display("[TB] FAIL burst_errors: got %0d expected 0", (perr_count - p0) + (ferr_count - f0)); end
  endtask

  task automatic test_parity_error;
    int e0, p0, f0;
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    wait_cycles(40);
    e0 = en_count; p0 = perr_count; f0 = ferr_count;
    send_frame(8'h6B, 1'b1, 1'b1, 11);
    wait_cycles(40);
    n_cmp++;
    if (perr_count - p0 !== 1) begin n_fail++; $display("[TB] FAIL parity_err_count: got %0d expected 1", perr_count - p0); end
    n_cmp++;
    if (en_count - e0 !== 0) begin n_fail++; $display("[TB] FAIL parity_no_en: got %0d expected 0", en_count - e0); end
    n_cmp++;
    if (ferr_count - f0 !== 0) begin n_fail++; $display("[TB] FAIL parity_no_frame_err: got %0d expected 0", ferr_count - f0); end
    n_cmp++;
    if (received_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL parity_data_hold: got %h expected 5a", received_data); end
  endtask

  task automatic test_glitch_and_framing;
    int e0, p0, f0;
    e0 = en_count; p0 = perr_count; f0 = ferr_count;
    // Data held low so a glitch that got through would look like a start bit.
    ps2_dat_in = 1'b0;
    wait_cycles(30);
    ps2_clk_in = 1'b0;
    wait_cycles(3);
    ps2_clk_in = 1'b1;
    wait_cycles(30);
    ps2_dat_in = 1'b1;
    wait_cycles(40);
    n_cmp++;
    if ((en_count - e0) + (perr_count - p0) + (ferr_count - f0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_outputs: got %0d pulses expected 0", (en_count - e0) + (perr_count - p0) + (ferr_count - f0));
    end
    send_frame(8'hF0, 1'b1, 1'b0, 11);
    ps2_dat_in = 1'b1;
    wait_cycles(40);
    n_cmp++;
    if (ferr_count - f0 !== 1) begin n_fail++; $display("[TB] FAIL stop0_frame_err: got %0d expected 1", ferr_count - f0); end
    n_cmp++;
    if ((en_count - e0) + (perr_count - p0) !== 0) begin n_fail++; $display("[TB] FAIL stop0_other_pulses: got %0d expected 0", (en_count - e0) + (perr_count - p0)); end
    n_cmp++;
    if (received_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL stop0_data_hold: got %h expected 5a", received_data); end
  endtask

  task automatic test_timeout_recovery;
    int e0, c0, f0, lat;
    bit seen;
    e0 = en_count; f0 = ferr_count;
    send_frame(8'h74, 1'b1, 1'b1, 5);
    ps2_dat_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < TB_TIMEOUT + 200; i++) begin
      @(negedge CLOCK_50);
      if (ferr_count != f0) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("[TB] FAIL timeout_seen: got no frame_error expected one within %0d cycles", TB_TIMEOUT + 200); end
    lat = ferr_cyc - last_fall_cyc;
    n_cmp++;
    if (seen && (lat < TB_TIMEOUT || lat > TB_TIMEOUT + SYNC + FILT + 6)) begin
      n_fail++;
      $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d", lat, TB_TIMEOUT, TB_TIMEOUT + SYNC + FILT + 6);
    end
    wait_cycles(20);
    n_cmp++;
    if (ferr_count - f0 !== 1 || en_count - e0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL timeout_pulses: got ferr %0d en %0d expected 1 0", ferr_count - f0, en_count - e0);
    end
    e0 = en_count; c0 = cap_n;
    send_frame(8'h74, 1'b1, 1'b1, 11);
    wait_cycles(40);
    n_cmp++;
    if (en_count - e0 !== 1 || cap[c0] !== 8'h74) begin
      n_fail++;
      $display("[TB] FAIL recovery_frame: got %0d pulses byte %h expected 1 74", en_count - e0, cap[c0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int e0, p0, f0;
    send_frame(8'h6B, 1'b0, 1'b1, 4);
    e0 = en_count; p0 = perr_count; f0 = ferr_count;
    ps2_dat_in = 1'b0;
    reset = 1'b1;
    wait_cycles(3);
    ps2_dat_in = 1'b1;
    reset = 1'b0;
    wait_cycles(TB_TIMEOUT + 100);
    n_cmp++;
    if ((en_count - e0) + (perr_count - p0) + (ferr_count - f0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_pulses: got %0d expected 0", (en_count - e0) + (perr_count - p0) + (ferr_count - f0));
    end
    n_cmp++;
    if (received_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_data: got %h expected 00", received_data); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_error();
    test_glitch_and_framing();
    test_timeout_recovery();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
